// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl
// Fetch controller between the IF stage and a slow, handshaked instruction
// memory. It holds a direct-mapped cache of LINES lines with one 32-bit word
// per line.
//   - Hits and misaligned fetches answer on the cycle after acceptance.
//   - A miss issues a single-word refill, fills the line and then answers.
//   - flush drops the next or outstanding response without cancelling a refill.
//   - inv_all clears every valid bit.
//   - hit_count and miss_count saturate at 16'hFFFF.
// Ports:
//   clock, reset                       rising-edge clock, synchronous active-high reset
//   req_valid, req_pc, req_ready       fetch request from IF
//   flush, inv_all                     redirect / whole-cache invalidate
//   resp_valid/_pc/_instr/_err         registered one-cycle response
//   mem_req_valid/_addr, mem_req_ready refill request channel
//   mem_resp_valid, mem_resp_data      refill data pulse
//   hit_count, miss_count              saturating statistics
module icache_fetch_ctrl #(
  parameter int LINES  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              req_ready,
  input  logic              flush,
  input  logic              inv_all,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_pc,
  output logic [31:0]       resp_instr,
  output logic              resp_err,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} state_t;

  state_t            state, state_nx;
  logic [LINES-1:0]  line_valid;
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [31:0]       line_data [LINES];
  logic [ADDR_W-1:0] miss_pc;
  logic              drop;

  logic [IDX_W-1:0]  req_idx, miss_idx;
  logic [TAG_W-1:0]  req_tag, miss_tag;
  logic              accept, misaligned, hit, fill;

  assign req_idx    = req_pc[IDX_W+1:2];
  assign req_tag    = req_pc[ADDR_W-1:IDX_W+2];
  assign miss_idx   = miss_pc[IDX_W+1:2];
  assign miss_tag   = miss_pc[ADDR_W-1:IDX_W+2];

  assign req_ready  = (state == IDLE) && !flush && !reset;
  assign accept     = req_valid && req_ready;
  assign misaligned = (req_pc[1:0] != 2'b00);
  assign hit        = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
  // The refill word is written whenever it arrives, even if the fetch was
  // flushed: the line is still worth keeping.
  assign fill       = (state == MISS_WAIT) && mem_resp_valid;

  assign mem_req_valid = (state == MISS_REQ);
  assign mem_req_addr  = mem_req_valid ? {miss_pc[ADDR_W-1:2], 2'b00} : '0;

  // NOTE: every output of a combinational block gets a default first, so that
  // no path leaves it unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (accept && !misaligned && !hit) state_nx = MISS_REQ;
      MISS_REQ:  if (mem_req_ready)                 state_nx = MISS_WAIT;
      MISS_WAIT: if (mem_resp_valid)                state_nx = IDLE;
      default:                                      state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so that every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      drop       <= 1'b0;
      miss_pc    <= '0;
      line_valid <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_instr <= '0;
      resp_pc    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nx;

      // The drop flag lives only for the current miss.
      if (state_nx == IDLE) drop <= 1'b0;
      else if (flush)       drop <= 1'b1;

      if (accept) miss_pc <= req_pc;

      // Invalidation wins over a fill that lands in the same cycle.
      if (inv_all)   line_valid           <= '0;
      else if (fill) line_valid[miss_idx] <= 1'b1;

      resp_valid <= 1'b0;
      if (accept) begin
        if (misaligned) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_instr <= '0;
          resp_pc    <= req_pc;
        end else if (hit) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_instr <= line_data[req_idx];
          resp_pc    <= req_pc;
        end
      end else if (fill) begin
        // A flush in the fill cycle itself also kills the response.
        resp_valid <= !drop && !flush;
        resp_err   <= 1'b0;
        resp_instr <= mem_resp_data;
        resp_pc    <= miss_pc;
      end

      if (accept && !misaligned && hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (accept && !misaligned && !hit && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone decide whether
  // their contents are meaningful, which keeps them plain RAM.
  always_ff @(posedge clock) begin
    if (fill) begin
      line_tag[miss_idx]  <= miss_tag;
      line_data[miss_idx] <= mem_resp_data;
    end
  end

endmodule
